// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_ERR  = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    // True when a writing stage targets a non-zero register read by a consumer.
    function automatic logic reg_match(
        input logic       we,
        input logic [4:0] rd,
        input logic [4:0] rs
    );
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_forward.sv
// Forward-select compare for one Execute operand; the M stage wins over W.
module hazard_forward
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output logic [1:0] fwd_sel
);

    always_comb begin
        fwd_sel = FWD_REG;
        if (reg_match(reg_write_m, rd_m, rs_e)) begin
            fwd_sel = FWD_M;
        end else if (reg_match(reg_write_w, rd_w, rs_e)) begin
            fwd_sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use/RAW stalls, branch flushes, memory wait FSM, perf counters.
// Build option: define FORWARDING_EN to enable E-stage operand forwarding.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           Rs1D,
    input  logic [4:0]           Rs2D,
    input  logic [4:0]           Rs1E,
    input  logic [4:0]           Rs2E,
    input  logic [4:0]           RdE,
    input  logic [4:0]           RdM,
    input  logic [4:0]           RdW,
    input  logic                 RegWriteE,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic                 ResultSrcE,
    input  logic                 PCSrcE,
    input  logic                 MemReqM,
    input  logic                 MemReadyM,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 StallM,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 FlushW,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic                 MemErr,
    output logic [CNT_WIDTH-1:0] StallCount,
    output logic [CNT_WIDTH-1:0] FlushCount
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hz_state_t         state;
    hz_state_t         state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_next;
    logic              freeze;
    logic              data_hazard;
    logic              branch_flush;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;

`ifdef FORWARDING_EN
    hazard_forward u_fwd_a (
        .rs_e        (Rs1E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd_sel     (fwd_a)
    );

    hazard_forward u_fwd_b (
        .rs_e        (Rs2E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd_sel     (fwd_b)
    );

    // With forwarding, only a load in E cannot be bypassed in time.
    assign data_hazard = reg_match(ResultSrcE, RdE, Rs1D)
                       | reg_match(ResultSrcE, RdE, Rs2D);
`else
    logic unused_fwd_inputs;

    assign fwd_a = FWD_REG;
    assign fwd_b = FWD_REG;
    // Without bypass, any pending write in E or M must retire before D reads.
    // W needs no check because the register file is write-first.
    assign data_hazard = reg_match(RegWriteE | ResultSrcE, RdE, Rs1D)
                       | reg_match(RegWriteE | ResultSrcE, RdE, Rs2D)
                       | reg_match(RegWriteM, RdM, Rs1D)
                       | reg_match(RegWriteM, RdM, Rs2D);
    assign unused_fwd_inputs = ^{Rs1E, Rs2E, RdW, RegWriteW};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        freeze        = 1'b0;
        StallF        = 1'b0;
        StallD        = 1'b0;
        StallE        = 1'b0;
        StallM        = 1'b0;
        FlushD        = 1'b0;
        FlushE        = 1'b0;
        FlushW        = 1'b0;
        branch_flush  = 1'b0;

        case (state)
            RUN: begin
                if (MemReqM && !MemReadyM) begin
                    freeze        = 1'b1;
                    state_next    = MEM_WAIT;
                    wait_cnt_next = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!MemReadyM) begin
                    freeze = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        state_next = MEM_ERR;
                    end else begin
                        wait_cnt_next = wait_cnt + WAIT_W'(1);
                    end
                end else begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end
            end
            MEM_ERR: begin
                freeze = 1'b1;
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase

        // Priority: reset bubble, memory freeze, taken branch, data hazard.
        if (!rst_n) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if (freeze) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD       = 1'b1;
            FlushE       = 1'b1;
            branch_flush = 1'b1;
        end else if (data_hazard) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    assign ForwardAE = rst_n ? fwd_a : FWD_REG;
    assign ForwardBE = rst_n ? fwd_b : FWD_REG;
    assign MemErr    = rst_n && (state == MEM_ERR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (StallF && (StallCount != '1)) begin
                StallCount <= StallCount + CNT_WIDTH'(1);
            end
            if (branch_flush && (FlushCount != '1)) begin
                FlushCount <= FlushCount + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=4, CNT_WIDTH=4); honours FORWARDING_EN.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
    logic [1:0] ForwardAE, ForwardBE;
    logic [3:0] StallCount, FlushCount;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemErr(MemErr), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0;
        PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
    endtask

    initial begin
        clear_inputs();
        rst_n  = 1'b0;
        PCSrcE = 1'b1;
        MemReqM = 1'b1;
        settle();
        check("rst_stallF", StallF, 0);
        check("rst_stallM", StallM, 0);
        check("rst_flushD", FlushD, 1);
        check("rst_flushE", FlushE, 1);
        check("rst_flushW", FlushW, 1);
        check("rst_fwdA", ForwardAE, 0);
        check("rst_memerr", MemErr, 0);
        tick();
        tick();
        check("rst_stallcnt", StallCount, 0);
        check("rst_flushcnt", FlushCount, 0);
        clear_inputs();
        rst_n = 1'b1;
        settle();
        check("idle_flushD", FlushD, 0);
        check("idle_stallF", StallF, 0);

`ifdef FORWARDING_EN
        RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1; Rs1E = 5; Rs2E = 5;
        settle();
        check("fwd_a_m", ForwardAE, 2'b10);
        check("fwd_b_m", ForwardBE, 2'b10);
        RegWriteM = 0;
        settle();
        check("fwd_a_w", ForwardAE, 2'b01);
        Rs1E = 0; RdM = 0;
        settle();
        check("fwd_a_x0", ForwardAE, 2'b00);
        clear_inputs();
        RegWriteM = 1; RdM = 3; Rs1D = 3;
        settle();
        check("fwd_m_nostall", StallF, 0);
        tick();
        check("fwd_cnt", StallCount, 0);
`else
        RegWriteM = 1; RdM = 3; Rs1D = 3; Rs1E = 3; RegWriteW = 1; RdW = 3;
        settle();
        check("raw_m_stallF", StallF, 1);
        check("raw_m_stallD", StallD, 1);
        check("raw_m_flushE", FlushE, 1);
        check("raw_m_flushD", FlushD, 0);
        check("raw_m_fwdA", ForwardAE, 0);
        tick();
        check("raw_m_cnt", StallCount, 1);
        clear_inputs();
        RegWriteE = 1; RdE = 9; Rs2D = 9;
        settle();
        check("raw_e_stallD", StallD, 1);
        tick();
        clear_inputs();
        RegWriteW = 1; RdW = 4; Rs1D = 4; RegWriteE = 1; RdE = 0; Rs2D = 0;
        settle();
        check("raw_w_x0_nostall", StallF, 0);
        tick();
        check("raw_cnt", StallCount, 2);
`endif

        clear_inputs();
        rst_n = 1'b0;
        tick();
        check("rst2_stallcnt", StallCount, 0);
        rst_n = 1'b1;

        // Load-use stall, then the same hazard overridden by a taken branch.
        ResultSrcE = 1; RegWriteE = 1; RdE = 7; Rs2D = 7;
        settle();
        check("lu_stallF", StallF, 1);
        check("lu_stallD", StallD, 1);
        check("lu_flushE", FlushE, 1);
        check("lu_flushD", FlushD, 0);
        tick();
        check("lu_cnt", StallCount, 1);
        PCSrcE = 1;
        settle();
        check("br_flushD", FlushD, 1);
        check("br_flushE", FlushE, 1);
        check("br_stallF", StallF, 0);
        check("br_stallD", StallD, 0);
        tick();
        check("br_flushcnt", FlushCount, 1);
        check("br_stallcnt", StallCount, 1);

        // Three not-ready cycles, ready on the last allowed cycle.
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("mw_stallM", StallM, 1);
            check("mw_stallF", StallF, 1);
            check("mw_flushW", FlushW, 1);
            check("mw_flushD", FlushD, 0);
            tick();
        end
        clear_inputs();
        MemReqM = 1; MemReadyM = 1;
        settle();
        check("mw_rel_stallM", StallM, 0);
        check("mw_rel_flushW", FlushW, 0);
        tick();
        check("mw_rel_memerr", MemErr, 0);
        clear_inputs();
        settle();
        check("mw_run_stallF", StallF, 0);
        check("mw_stallcnt", StallCount, 4);
        check("mw_flushcnt", FlushCount, 1);

        // Timeout: error at the 4th edge, sticky until reset.
        MemReqM = 1; MemReadyM = 0;
        tick();
        check("to_edge1", MemErr, 0);
        tick();
        tick();
        check("to_edge3", MemErr, 0);
        tick();
        check("to_edge4", MemErr, 1);
        check("to_stallcnt", StallCount, 8);
        MemReqM = 0; MemReadyM = 1;
        settle();
        check("to_hold_stallF", StallF, 1);
        check("to_hold_flushW", FlushW, 1);
        tick();
        check("to_sticky", MemErr, 1);
        check("to_stallcnt2", StallCount, 9);
        clear_inputs();
        rst_n = 1'b0;
        settle();
        check("to_rst_memerr", MemErr, 0);
        check("to_rst_stallF", StallF, 0);
        tick();
        check("to_rst_stallcnt", StallCount, 0);
        check("to_rst_flushcnt", FlushCount, 0);
        rst_n = 1'b1;
        settle();
        check("to_after_memerr", MemErr, 0);
        check("to_after_stallF", StallF, 0);

        // Counter saturation at 4 bits.
        ResultSrcE = 1; RegWriteE = 1; RdE = 7; Rs1D = 7;
        for (int i = 0; i < 20; i++) tick();
        check("sat_stallcnt", StallCount, 15);
        clear_inputs();
        PCSrcE = 1;
        for (int i = 0; i < 20; i++) tick();
        check("sat_flushcnt", FlushCount, 15);
        check("sat_stallcnt_hold", StallCount, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
